status_reg: RTL and testbench
=============================

Name: status_reg

Overview:
- Processor status register (P) and interrupt-request front end, placed directly downstream of the ALU.
- Captures the ALU status outputs (carry, zero, overflow, negative) under per-flag control and handles the flag instructions and PLP/RTI/BIT loads.
- Feeds back into the ALU: carry-in (cflag) and decimal-mode enable (decEn).
- Also evaluates branch conditions, and latches and prioritises NMI/IRQ requests against the I flag.

Parameters:
- RESET_P, 8'h24, P image after reset: I=1, bit5=1, all other flags 0.

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- aluC  in  1  ALU carry out
- aluZ  in  1  ALU zero
- aluV  in  1  ALU overflow
- aluN  in  1  ALU negative
- ldc  in  1  load C from aluC
- ldz  in  1  load Z from aluZ
- ldv  in  1  load V from aluV
- ldn  in  1  load N from aluN
- ldbus  in  1  load N,V,D,I,Z,C from dbIn (PLP/RTI)
- bitop  in  1  BIT: N<=dbIn[7], V<=dbIn[6], Z<=aluZ
- dbIn  in  8  internal data bus in
- sec, clc, sei, cli, sed, cld, clv  in  1 each  flag instructions
- brk  in  1  B bit value for the push image
- pdboa  in  1  drive push image onto dbOut
- sync  in  1  opcode-fetch cycle (instruction boundary)
- irqN  in  1  level IRQ, active low
- nmiN  in  1  edge NMI, active low
- intack  in  1  interrupt sequence entered
- brsel  in  2  branch flag select: 00 N, 01 V, 10 C, 11 Z
- brval  in  1  required flag value for a taken branch
- p  out  8  {N,V,1,0,D,I,Z,C}
- dbOut  out  8  {N,V,1,brk,D,I,Z,C} when pdboa=1, else 8'hzz
- cflag  out  1  C, to ALU cin
- decEn  out  1  D, to ALU decEn
- taken  out  1  selected flag == brval (combinational)
- intreq  out  1  interrupt pending
- intnmi  out  1  1 = pending request is NMI

Behaviour:
- Reset (reset=1 at posedge):
  - P <= RESET_P, so p=8'h24, cflag=0, decEn=0.
  - nmiPrev<=1, nmiPend<=0, imask<=1, so intreq=0 and intnmi=0.
  - Reset overrides every other input, including mid-instruction.
- Flag update priority, per flag, at each posedge:
  1. reset
  2. intack (I only: I<=1)
  3. ldbus
  4. bitop (N,V,Z)
  5. set/clear instructions
  6. ALU loads (ldc/ldz/ldv/ldn)
  7. hold
- Set and clear of the same flag asserted together: clear wins.
- ldbus ignores dbIn[5:4]; p[5] is always 1 and p[4] always 0.
- Flags are registered with 1-cycle latency: an ALU result flag is visible on p in the cycle after its load strobe. This matches the ALU capturing its store on the same edge.
- decEn and cflag are taken directly from the register, so there is no combinational loop through the ALU.
- Branch: taken = (brsel-selected flag == brval). Purely combinational from the current P.
- NMI:
  - nmiPrev <= nmiN every cycle.
  - A falling edge (nmiPrev=1, nmiN=0) sets nmiPend.
  - intack with intnmi=1 clears nmiPend.
  - A new edge in the same cycle as that intack keeps nmiPend set (set wins).
  - A held-low nmiN produces no further requests.
- IRQ mask:
  - imask <= I only on cycles with sync=1, otherwise it holds.
  - As a result, CLI/SEI/PLP affect IRQ recognition only from the next instruction boundary.
- IRQ pending: irqPend = ~irqN & ~imask (level, not latched).
- Outputs: intreq = nmiPend | irqPend; intnmi = nmiPend (NMI has priority).
- intack:
  - Sets I.
  - Also loads imask<=1 in the same cycle, so a still-asserted IRQ is masked immediately.
- dbOut is driven only while pdboa=1; it is high-Z otherwise.

Test Plan:
- Reset then idle -> p=8'h24, cflag=0, decEn=0, intreq=0, dbOut=zz. Set pdboa=1, brk=1 -> dbOut=8'h34.
- Flag sources:
  - aluN=1, aluZ=0, aluC=1, aluV=1 with ldn, ldz, ldc pulsed (ldv low) -> next cycle p=8'hA5, V unchanged, cflag=1.
  - sec and clc together -> C=0.
- Load/BIT and branches:
  - ldbus with dbIn=8'hFF -> p=8'hEF.
  - bitop with dbIn=8'h40, aluZ=1 -> N=0, V=1, Z=1.
  - brsel=11, brval=1 -> taken=1.
- IRQ mask timing:
  - Reset state, irqN=0 -> intreq=0.
  - cli, then sync=0 for 3 cycles -> intreq stays 0.
  - sync=1 -> intreq=1 next cycle, intnmi=0.
  - intack -> I=1 and intreq=0 next cycle.
- NMI edge:
  - nmiN 1->0 -> intreq=1, intnmi=1.
  - Holding nmiN low through intack -> intreq drops and does not re-assert.
  - nmiN 1->0 again -> request re-asserts.
- Reset mid-operation: assert reset with nmiPend=1 and ldbus=1, dbIn=8'h00 -> p=8'h24, intreq=0.

Source files
------------

// File: rtl/status_reg.sv
// Processor status register (P) with flag update logic, branch condition
// evaluation and NMI/IRQ request front end.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       aluC,
  input  logic       aluZ,
  input  logic       aluV,
  input  logic       aluN,
  input  logic       ldc,
  input  logic       ldz,
  input  logic       ldv,
  input  logic       ldn,
  input  logic       ldbus,
  input  logic       bitop,
  input  logic [7:0] dbIn,
  input  logic       sec,
  input  logic       clc,
  input  logic       sei,
  input  logic       cli,
  input  logic       sed,
  input  logic       cld,
  input  logic       clv,
  input  logic       brk,
  input  logic       pdboa,
  input  logic       sync,
  input  logic       irqN,
  input  logic       nmiN,
  input  logic       intack,
  input  logic [1:0] brsel,
  input  logic       brval,
  output logic [7:0] p,
  output logic [7:0] dbOut,
  output logic       cflag,
  output logic       decEn,
  output logic       taken,
  output logic       intreq,
  output logic       intnmi
);

  // Bit positions in the P image
  localparam int C_B = 0;
  localparam int Z_B = 1;
  localparam int I_B = 2;
  localparam int D_B = 3;
  localparam int V_B = 6;
  localparam int N_B = 7;

  logic [7:0] p_r;
  logic [7:0] p_s;
  logic       nmi_prev_r;
  logic       nmi_pend_r;
  logic       nmi_pend_s;
  logic       imask_r;
  logic       imask_s;
  logic       irq_pend_s;

  function automatic logic branch_flag(input logic [1:0] sel, input logic [7:0] pimg);
    case (sel)
      2'b00:   branch_flag = pimg[N_B];
      2'b01:   branch_flag = pimg[V_B];
      2'b10:   branch_flag = pimg[C_B];
      2'b11:   branch_flag = pimg[Z_B];
      default: branch_flag = 1'b0;
    endcase
  endfunction

  // Next P image: bus load, then BIT, then set/clear (clear wins), then ALU loads; intack forces I
  always_comb begin
    p_s = p_r;
    if (ldbus) begin
      p_s = (dbIn & 8'hCF) | 8'h20;
    end else begin
      if (bitop)    p_s[N_B] = dbIn[7];
      else if (ldn) p_s[N_B] = aluN;
      else          p_s[N_B] = p_r[N_B];

      if (bitop)    p_s[V_B] = dbIn[6];
      else if (clv) p_s[V_B] = 1'b0;
      else if (ldv) p_s[V_B] = aluV;
      else          p_s[V_B] = p_r[V_B];

      if (cld)      p_s[D_B] = 1'b0;
      else if (sed) p_s[D_B] = 1'b1;
      else          p_s[D_B] = p_r[D_B];

      if (cli)      p_s[I_B] = 1'b0;
      else if (sei) p_s[I_B] = 1'b1;
      else          p_s[I_B] = p_r[I_B];

      if (bitop)    p_s[Z_B] = aluZ;
      else if (ldz) p_s[Z_B] = aluZ;
      else          p_s[Z_B] = p_r[Z_B];

      if (clc)      p_s[C_B] = 1'b0;
      else if (sec) p_s[C_B] = 1'b1;
      else if (ldc) p_s[C_B] = aluC;
      else          p_s[C_B] = p_r[C_B];
    end
    p_s[I_B] = p_s[I_B] | intack;
  end

  // Interrupt bookkeeping: NMI edge latch (new edge beats acknowledge) and boundary-sampled I mask
  always_comb begin
    nmi_pend_s = nmi_pend_r;
    imask_s    = imask_r;
    if (nmi_prev_r && !nmiN)         nmi_pend_s = 1'b1;
    else if (intack && nmi_pend_r)   nmi_pend_s = 1'b0;
    else                             nmi_pend_s = nmi_pend_r;

    if (intack)    imask_s = 1'b1;
    else if (sync) imask_s = p_r[I_B];
    else           imask_s = imask_r;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      p_r        <= (RESET_P & 8'hCF) | 8'h20;
      nmi_prev_r <= 1'b1;
      nmi_pend_r <= 1'b0;
      imask_r    <= 1'b1;
    end else begin
      p_r        <= p_s;
      nmi_prev_r <= nmiN;
      nmi_pend_r <= nmi_pend_s;
      imask_r    <= imask_s;
    end
  end

  assign irq_pend_s = ~irqN & ~imask_r;

  assign p      = p_r;
  assign cflag  = p_r[C_B];
  assign decEn  = p_r[D_B];
  assign taken  = (branch_flag(brsel, p_r) == brval);
  assign intreq = nmi_pend_r | irq_pend_s;
  assign intnmi = nmi_pend_r;
  assign dbOut  = pdboa ? {p_r[7:6], 1'b1, brk, p_r[3:0]} : 8'hzz;

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed vector table, hand sequences
// for latency/bus-image corners, and randomized run against a flag-level model.
module tb_status_reg;

  logic       clk;
  logic       reset;
  logic       aluC, aluZ, aluV, aluN;
  logic       ldc, ldz, ldv, ldn;
  logic       ldbus, bitop;
  logic [7:0] dbIn;
  logic       sec, clc, sei, cli, sed, cld, clv;
  logic       brk, pdboa, sync, irqN, nmiN, intack;
  logic [1:0] brsel;
  logic       brval;
  logic [7:0] p;
  wire  [7:0] dbOut;
  logic       cflag, decEn, taken, intreq, intnmi;

  int n_asserts;
  int n_fail;

  // Reference model state
  logic [7:0] mp;
  logic       mprev, mpend, mimask;

  typedef struct packed {
    logic       rst;
    logic [3:0] ld;     // {ldn,ldv,ldz,ldc}
    logic [3:0] alu;    // {N,V,Z,C}
    logic [6:0] sc;     // {sec,clc,sei,cli,sed,cld,clv}
    logic       ldb;
    logic       bop;
    logic [7:0] db;
    logic       syn;
    logic       irq_n;
    logic       nmi_n;
    logic       ack;
    logic [1:0] bsel;
    logic       bval;
    logic [7:0] ep;
    logic       et;
    logic       eirq;
    logic       enmi;
  } vec_t;

  vec_t tbl [0:27];

  status_reg dut (
    .clk(clk), .reset(reset),
    .aluC(aluC), .aluZ(aluZ), .aluV(aluV), .aluN(aluN),
    .ldc(ldc), .ldz(ldz), .ldv(ldv), .ldn(ldn),
    .ldbus(ldbus), .bitop(bitop), .dbIn(dbIn),
    .sec(sec), .clc(clc), .sei(sei), .cli(cli), .sed(sed), .cld(cld), .clv(clv),
    .brk(brk), .pdboa(pdboa), .sync(sync), .irqN(irqN), .nmiN(nmiN), .intack(intack),
    .brsel(brsel), .brval(brval),
    .p(p), .dbOut(dbOut), .cflag(cflag), .decEn(decEn), .taken(taken),
    .intreq(intreq), .intnmi(intnmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    {aluN, aluV, aluZ, aluC} = 4'h0;
    {ldn, ldv, ldz, ldc} = 4'h0;
    {sec, clc, sei, cli, sed, cld, clv} = 7'h00;
    ldbus = 1'b0; bitop = 1'b0; dbIn = 8'h00;
    brk = 1'b0; pdboa = 1'b0; sync = 1'b0;
    irqN = 1'b1; nmiN = 1'b1; intack = 1'b0;
    brsel = 2'b00; brval = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v);
    reset = v.rst;
    {ldn, ldv, ldz, ldc} = v.ld;
    {aluN, aluV, aluZ, aluC} = v.alu;
    {sec, clc, sei, cli, sed, cld, clv} = v.sc;
    ldbus = v.ldb; bitop = v.bop; dbIn = v.db;
    sync = v.syn; irqN = v.irq_n; nmiN = v.nmi_n; intack = v.ack;
    brsel = v.bsel; brval = v.bval;
  endtask

  // Applies one clock of the architectural rules to the model; later rules override earlier ones
  task automatic model_step();
    logic [7:0] np;
    logic       npend;
    if (reset) begin
      mp = 8'h24; mprev = 1'b1; mpend = 1'b0; mimask = 1'b1;
    end else begin
      np = mp;
      if (ldc) np[0] = aluC;
      if (ldz) np[1] = aluZ;
      if (ldv) np[6] = aluV;
      if (ldn) np[7] = aluN;
      if (sec) np[0] = 1'b1;
      if (sei) np[2] = 1'b1;
      if (sed) np[3] = 1'b1;
      if (clc) np[0] = 1'b0;
      if (cli) np[2] = 1'b0;
      if (cld) np[3] = 1'b0;
      if (clv) np[6] = 1'b0;
      if (bitop) begin np[7] = dbIn[7]; np[6] = dbIn[6]; np[1] = aluZ; end
      if (ldbus) np = {dbIn[7:6], 2'b10, dbIn[3:0]};
      if (intack) np[2] = 1'b1;
      npend = mpend;
      if (intack && mpend) npend = 1'b0;
      if (mprev && !nmiN) npend = 1'b1;
      if (intack) mimask = 1'b1;
      else if (sync) mimask = mp[2];
      mpend = npend;
      mprev = nmiN;
      mp = np;
    end
  endtask

  task automatic model_compare(input int cyc);
    int pos [4];
    logic mt;
    pos = '{7, 6, 0, 1};
    mt = (mp[pos[brsel]] == brval);
    chk8($sformatf("rnd%0d p", cyc), p, mp);
    chk1($sformatf("rnd%0d cflag", cyc), cflag, mp[0]);
    chk1($sformatf("rnd%0d decEn", cyc), decEn, mp[3]);
    chk1($sformatf("rnd%0d taken", cyc), taken, mt);
    chk1($sformatf("rnd%0d intreq", cyc), intreq, mpend | (~irqN & ~mimask));
    chk1($sformatf("rnd%0d intnmi", cyc), intnmi, mpend);
    if (pdboa) chk8($sformatf("rnd%0d dbOut", cyc), dbOut, {mp[7:6], 1'b1, brk, mp[3:0]});
  endtask

  initial begin
    n_asserts = 0;
    n_fail = 0;
    idle_inputs();

    //        rst  ld     alu    sc          ldb  bop  db     syn  irqn nmin ack  bsel   bval ep     et   eirq enmi
    tbl[0]  = '{1'b1,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[1]  = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b10,1'b1,8'h24,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,4'hB,4'hD,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b10,1'b1,8'hA5,1'b1,1'b0,1'b0};
    tbl[3]  = '{1'b0,4'h0,4'h0,7'b1100000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b10,1'b0,8'hA4,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,4'h0,4'h0,7'b0000000,1'b1,1'b0,8'hFF,1'b0,1'b1,1'b1,1'b0,2'b11,1'b1,8'hEF,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,4'h0,4'h2,7'b0000000,1'b0,1'b1,8'h40,1'b0,1'b1,1'b1,1'b0,2'b11,1'b1,8'h6F,1'b1,1'b0,1'b0};
    tbl[6]  = '{1'b0,4'h0,4'h0,7'b0100011,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b01,1'b0,8'h26,1'b1,1'b0,1'b0};
    tbl[7]  = '{1'b0,4'h0,4'h0,7'b0000100,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b1,8'h2E,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,4'h2,4'h0,7'b0000110,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b11,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[9]  = '{1'b0,4'h0,4'h2,7'b0000000,1'b1,1'b1,8'h81,1'b0,1'b1,1'b1,1'b0,2'b00,1'b1,8'hA1,1'b1,1'b0,1'b0};
    tbl[10] = '{1'b1,4'h0,4'h0,7'b0000000,1'b1,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b0,4'h0,4'h0,7'b0001000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h20,1'b1,1'b0,1'b0};
    tbl[13] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h20,1'b1,1'b0,1'b0};
    tbl[14] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h20,1'b1,1'b0,1'b0};
    tbl[15] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h20,1'b1,1'b0,1'b0};
    tbl[16] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,8'h20,1'b1,1'b1,1'b0};
    tbl[17] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[18] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[19] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,8'h24,1'b1,1'b1,1'b1};
    tbl[20] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[21] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[22] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[23] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,8'h24,1'b1,1'b1,1'b1};
    tbl[24] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b1,1'b1};
    tbl[25] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,8'h24,1'b1,1'b1,1'b1};
    tbl[26] = '{1'b1,4'h0,4'h0,7'b0000000,1'b1,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};
    tbl[27] = '{1'b0,4'h0,4'h0,7'b0000000,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,8'h24,1'b1,1'b0,1'b0};

    for (int i = 0; i < 28; i++) begin
      apply_vec(tbl[i]);
      tick();
      chk8($sformatf("row%0d p", i), p, tbl[i].ep);
      chk1($sformatf("row%0d taken", i), taken, tbl[i].et);
      chk1($sformatf("row%0d intreq", i), intreq, tbl[i].eirq);
      chk1($sformatf("row%0d intnmi", i), intnmi, tbl[i].enmi);
    end

    // Push image on the bus, including combinational follow of brk
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pdboa = 1'b1; brk = 1'b1;
    tick();
    chk8("push_reset", dbOut, 8'h34);
    chk1("reset_cflag", cflag, 1'b0);
    chk1("reset_decEn", decEn, 1'b0);
    ldbus = 1'b1; dbIn = 8'hFF; brk = 1'b0;
    tick();
    ldbus = 1'b0;
    chk8("push_ff_brk0", dbOut, 8'hEF);
    brk = 1'b1;
    #1;
    chk8("push_ff_brk1", dbOut, 8'hFF);
    pdboa = 1'b0;

    // One-cycle flag latency and register-sourced cflag/decEn
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ldc = 1'b1; aluC = 1'b1;
    @(negedge clk);
    chk1("latency_before", cflag, 1'b0);
    tick();
    chk1("latency_after", cflag, 1'b1);
    ldc = 1'b0; aluC = 1'b0; sed = 1'b1;
    tick();
    sed = 1'b0;
    chk1("cflag_hold", cflag, 1'b1);
    chk1("decEn_set", decEn, 1'b1);
    brsel = 2'b10; brval = 1'b1;
    #1;
    chk1("taken_comb_1", taken, 1'b1);
    brval = 1'b0;
    #1;
    chk1("taken_comb_0", taken, 1'b0);

    // Randomized run against the model
    idle_inputs();
    reset = 1'b1;
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset  = ($urandom_range(0, 63) == 0);
      ldc    = ($urandom_range(0, 3) == 0);
      ldz    = ($urandom_range(0, 3) == 0);
      ldv    = ($urandom_range(0, 3) == 0);
      ldn    = ($urandom_range(0, 3) == 0);
      {aluN, aluV, aluZ, aluC} = 4'($urandom_range(0, 15));
      sec    = ($urandom_range(0, 7) == 0);
      clc    = ($urandom_range(0, 7) == 0);
      sei    = ($urandom_range(0, 7) == 0);
      cli    = ($urandom_range(0, 7) == 0);
      sed    = ($urandom_range(0, 7) == 0);
      cld    = ($urandom_range(0, 7) == 0);
      clv    = ($urandom_range(0, 7) == 0);
      ldbus  = ($urandom_range(0, 7) == 0);
      bitop  = ($urandom_range(0, 7) == 0);
      dbIn   = 8'($urandom_range(0, 255));
      sync   = ($urandom_range(0, 2) == 0);
      irqN   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) nmiN = ~nmiN;
      intack = ($urandom_range(0, 7) == 0);
      brsel  = 2'($urandom_range(0, 3));
      brval  = 1'($urandom_range(0, 1));
      pdboa  = 1'($urandom_range(0, 1));
      brk    = 1'($urandom_range(0, 1));
      model_step();
      tick();
      model_compare(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
